mem_request_queue: RTL and testbench
====================================

MEM_REQUEST_QUEUE -- requirements
Module: mem_request_queue

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, data width; ADWIDTH, 16, address width; DEPTH, 4, request FIFO entries (power of 2); TIMEOUT, 15, max cycles waiting for controller acceptance.
REQ-002 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port req_valid  input  1  CPU request present.
REQ-005 Port req_ready  output  1  queue can accept a request.
REQ-006 Port req_rw  input  1  1 = write, 0 = read.
REQ-007 Port req_addr  input  ADWIDTH  request address.
REQ-008 Port req_wdata  input  WIDTH  write data.
REQ-009 Port rsp_valid  output  1  one-cycle pulse: read data valid.
REQ-010 Port rsp_rdata  output  WIDTH  read data, held until next read completes.
REQ-011 Port Valid  output  1  request strobe to memory controller.
REQ-012 Port RW  output  1  1 = write, 0 = read, to memory controller.
REQ-013 Port Addr  output  ADWIDTH  address to memory controller.
REQ-014 Port data  inout  WIDTH  shared data bus to memory controller.
REQ-015 Port ready  input  1  controller ready/done indication.
REQ-016 Port busy  output  1  high when FIFO non-empty or FSM not IDLE.
REQ-017 Port err  output  1  sticky timeout flag.

Function
REQ-018 Push SHALL occur on a clk edge where req_valid && req_ready; req_ready SHALL equal !full of the current cycle, so a simultaneous pop never admits a push when full.
REQ-019 FIFO SHALL store {rw, addr, wdata}, issue in order, wrap pointers modulo DEPTH; count SHALL range 0..DEPTH.
REQ-020 FSM states: IDLE, REQ, WAIT, REL.
REQ-021 IDLE: if FIFO non-empty and ready==1, pop head into issue registers and go to REQ next cycle; otherwise stay.
REQ-022 REQ: Valid=1, RW/Addr from issue registers; on ready==0 go to WAIT; if ready stays 1 for TIMEOUT cycles, set err, drop the request, go to REL.
REQ-023 WAIT: Valid=1 held; on ready==1 go to REL; for reads, capture data into rsp_rdata and pulse rsp_valid in that same cycle.
REQ-024 REL: Valid=0 for exactly one cycle, then IDLE; minimum request-to-request spacing is therefore 4 cycles.
REQ-025 Bus data SHALL be driven with issue wdata only while Valid && RW; high-impedance otherwise.
REQ-026 Valid, RW, Addr SHALL be registered outputs, stable for the whole REQ/WAIT interval.
REQ-027 Timeout counter SHALL clear on entry to REQ and saturate at TIMEOUT.
REQ-028 err SHALL remain set until reset; later requests SHALL still be serviced.
REQ-029 Push into an empty FIFO while IDLE SHALL be issued no earlier than the next cycle (no bypass).

Reset
REQ-030 On reset assertion, asynchronously: state=IDLE, FIFO pointers/count=0, Valid=0, RW=0, Addr=0, rsp_valid=0, rsp_rdata=0, err=0, busy=0, req_ready=1 after release, data bus high-impedance.
REQ-031 Reset mid-transaction SHALL abandon the in-flight request and all queued entries without any rsp_valid pulse.

Structure
REQ-032 Shared package mem_pkg SHALL hold the FSM state encoding and default WIDTH/ADWIDTH constants, shared with the memory controller.
REQ-033 FIFO SHALL be a sub-module req_fifo (push/pop/full/empty/count); FSM, timeout counter and tristate stay in the top.

Verification
REQ-034 Single write addr 0x0010 data 0xDEADBEEF, controller model drops ready 1 cycle after Valid, raises 2 later -> Valid high 4 cycles, data driven 0xDEADBEEF, RW=1, no rsp_valid.
REQ-035 Read addr 0x0020, model returns 0x12345678 -> exactly one rsp_valid pulse, rsp_rdata=0x12345678, bus tristated throughout.
REQ-036 Push 5 back-to-back requests with controller stalled -> req_ready low after 4th; 5th accepted after first pop; issue order preserved.
REQ-037 Model never drops ready -> err set after 15 REQ cycles, Valid falls, next queued request still completes.
REQ-038 Assert reset during WAIT with 3 queued -> Valid=0, busy=0, req_ready=1 immediately; no rsp_valid afterwards.

Source files
------------

// File: rtl/mem_pkg.sv
// Definitions shared by the CPU-side request queue and the memory controller:
// the handshake FSM encoding and the default bus widths.
package mem_pkg;

  localparam int MEM_WIDTH   = 32;
  localparam int MEM_ADWIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_REL  = 2'd3
  } mem_state_e;

endpackage

// File: rtl/req_fifo.sv
// In-order request FIFO. DEPTH must be a power of two, so the pointers wrap on
// their own; the count spans 0..DEPTH so that full and empty can be told apart.
module req_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Entry storage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_request_queue.sv
// Queues CPU memory requests and issues them one at a time over a
// Valid/ready handshake on a shared tristate data bus, with a stuck-ready timeout.
module mem_request_queue
  import mem_pkg::*;
#(
  parameter int WIDTH   = MEM_WIDTH,
  parameter int ADWIDTH = MEM_ADWIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_rw,
  input  logic [ADWIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  output logic               rsp_valid,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               Valid,
  output logic               RW,
  output logic [ADWIDTH-1:0] Addr,
  inout  wire  [WIDTH-1:0]   data,
  input  logic               ready,
  output logic               busy,
  output logic               err
);

  localparam int EW = 1 + ADWIDTH + WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  mem_state_e       r_state;
  mem_state_e       w_next;
  logic [EW-1:0]    w_head;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic             w_pop;
  logic             w_timeout;
  logic             w_rd_done;
  logic             r_valid;
  logic             r_rw;
  logic [ADWIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [TW-1:0]    r_tcnt;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rdata;
  logic             r_err;

  req_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (req_valid),
    .i_pop   (w_pop),
    .i_wdata ({req_rw, req_addr, req_wdata}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign req_ready = !w_full;
  assign busy      = (r_state != ST_IDLE) || (w_count != '0);
  assign Valid     = r_valid;
  assign RW        = r_rw;
  assign Addr      = r_addr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign err       = r_err;
  assign data      = (r_valid && r_rw) ? r_wdata : {WIDTH{1'bz}};

  // Handshake state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-cycle handshake decisions.
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_timeout = 1'b0;
    w_rd_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && ready) begin
          w_pop  = 1'b1;
          w_next = ST_REQ;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!ready) begin
          w_next = ST_WAIT;
        end else if (r_tcnt == T_LAST) begin
          w_timeout = 1'b1;
          w_next    = ST_REL;
        end else begin
          w_next = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (ready) begin
          w_rd_done = !r_rw;
          w_next    = ST_REL;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_REL: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Issue registers, timeout counter, response capture and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_tcnt      <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_valid     <= (w_next == ST_REQ) || (w_next == ST_WAIT);
      r_rsp_valid <= w_rd_done;
      if (w_pop) begin
        {r_rw, r_addr, r_wdata} <= w_head;
        r_tcnt <= '0;
      end else if ((r_state == ST_REQ) && ready && (r_tcnt != T_MAX)) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_rd_done) begin
        r_rdata <= data;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_request_queue.sv
// Randomised scoreboard bench: a behavioural memory-controller model drives
// ready/read data, and a monitor checks issue order, bus use and responses.
module tb_mem_request_queue;

  localparam int W  = 32;
  localparam int AW = 16;
  localparam int TO = 15;

  typedef struct packed { logic rw; logic [AW-1:0] addr; logic [W-1:0] wdata; } req_t;
  typedef struct { int dur; bit to; } dur_t;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_rw;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_wdata;
  logic          rsp_valid;
  logic [W-1:0]  rsp_rdata;
  logic          Valid;
  logic          RW;
  logic [AW-1:0] Addr;
  wire  [W-1:0]  data_bus;
  logic          ready;
  logic          busy;
  logic          err;

  logic          tb_drv;
  logic [W-1:0]  tb_val;

  req_t          q_issue[$];
  dur_t          q_dur[$];
  logic [W-1:0]  q_rsp[$];

  int n_vec = 0;
  int n_err = 0;
  int rsp_count = 0;
  int last_dur = 0;
  int ctl_mode = 0;   // 0 normal, 2 stall while idle, 3 hang after first issue
  int to_left = 0;    // transactions for which ready is never dropped
  bit ctl_fix = 1'b0;
  int fix_h = 0;
  int fix_l = 1;
  logic [W-1:0] fix_rd = '0;

  mem_request_queue dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .Valid(Valid), .RW(RW),
    .Addr(Addr), .data(data_bus), .ready(ready), .busy(busy), .err(err)
  );

  assign tb_drv   = !(Valid && RW);
  assign data_bus = tb_drv ? tb_val : {W{1'bz}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Controller model: reacts to each issued request with a chosen ready pattern.
  initial begin : controller
    int nh;
    int nl;
    dur_t d;
    logic [W-1:0] rd;
    ready  = 1'b1;
    tb_val = '0;
    forever begin
      @(negedge clk);
      if (ctl_mode == 2) begin
        ready = 1'b0;
      end else if (Valid && !reset) begin
        if (ctl_mode == 3) begin
          ready = 1'b0;
          for (int k = 0; k < 2000 && ctl_mode == 3; k++) @(negedge clk);
          ready = 1'b1;
        end else if (to_left > 0) begin
          to_left--;
          d.dur = TO; d.to = 1'b1;
          q_dur.push_back(d);
          for (int k = 0; k < TO + 4 && Valid; k++) @(negedge clk);
        end else begin
          nh = ctl_fix ? fix_h : int'($urandom_range(0, 2));
          nl = ctl_fix ? fix_l : int'($urandom_range(1, 3));
          d.dur = nh + nl + 1; d.to = 1'b0;
          q_dur.push_back(d);
          repeat (nh) @(negedge clk);
          ready = 1'b0;
          repeat (nl) @(negedge clk);
          ready = 1'b1;
          if (!RW) begin
            rd = ctl_fix ? fix_rd : $urandom;
            tb_val = rd;
            q_rsp.push_back(rd);
          end
          @(negedge clk);
          tb_val = '0;
        end
      end else begin
        ready = 1'b1;
      end
    end
  end

  // Monitor: issue order, handshake stability, bus ownership, responses, err.
  initial begin : monitor
    bit   prev_valid = 1'b0;
    bit   prev_rsp = 1'b0;
    bit   exp_err = 1'b0;
    int   hi_cnt = 0;
    logic [W-1:0] last_rd = '0;
    req_t cur = '0;
    dur_t d;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        prev_valid = 1'b0; prev_rsp = 1'b0; exp_err = 1'b0; hi_cnt = 0; last_rd = '0;
      end else begin
        if (tb_drv) check("bus_release", data_bus, tb_val);
        if (Valid && !prev_valid) begin
          hi_cnt = 0;
          if (q_issue.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL issue: Valid rose with addr %0h, required no issue (queue empty)", Addr);
          end else begin
            cur = q_issue.pop_front();
            check("issue_rw", 32'(RW), 32'(cur.rw));
            check("issue_addr", 32'(Addr), 32'(cur.addr));
          end
        end
        if (Valid) begin
          hi_cnt++;
          check("hold_rw", 32'(RW), 32'(cur.rw));
          check("hold_addr", 32'(Addr), 32'(cur.addr));
          if (cur.rw) check("wdata_bus", data_bus, cur.wdata);
        end
        if (!Valid && prev_valid) begin
          last_dur = hi_cnt;
          if (q_dur.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL valid_len: Valid fell after %0d cycles, required none expected", hi_cnt);
          end else begin
            d = q_dur.pop_front();
            check("valid_len", 32'(hi_cnt), 32'(d.dur));
            if (d.to) exp_err = 1'b1;
          end
        end
        if (rsp_valid) begin
          rsp_count++;
          check("rsp_pulse", 32'(prev_rsp), 32'd0);
          if (q_rsp.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL rsp: rsp_valid with %0h, required no response", rsp_rdata);
          end else begin
            last_rd = q_rsp.pop_front();
          end
        end
        check("rsp_rdata", rsp_rdata, last_rd);
        check("err", 32'(err), 32'(exp_err));
        prev_valid = Valid;
        prev_rsp = rsp_valid;
      end
    end
  end

  task automatic present(input logic rw, input logic [AW-1:0] a, input logic [W-1:0] d);
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
  endtask

  task automatic accept();
    bit ok = 1'b0;
    req_t r;
    for (int k = 0; k < 400; k++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL push_accept: req_ready 0, required 1 within 400 cycles");
    end else begin
      r.rw = req_rw; r.addr = req_addr; r.wdata = req_wdata;
      q_issue.push_back(r);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic send(input logic rw, input logic [AW-1:0] a, input logic [W-1:0] d);
    present(rw, a, d);
    accept();
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b0 | 1'b1; break; end
    end
    check("idle_reached", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int rc;
    reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(Valid), 32'd0);
    check("rst_rw", 32'(RW), 32'd0);
    check("rst_addr", 32'(Addr), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_bus", data_bus, 32'd0);
    reset = 1'b0;

    // Single write, ready dropped one cycle after Valid and raised two later.
    ctl_fix = 1'b1; fix_h = 1; fix_l = 2;
    send(1'b1, 16'h0010, 32'hDEADBEEF);
    wait_idle();
    check("wr_valid_cycles", 32'(last_dur), 32'd4);
    check("wr_no_rsp", 32'(rsp_count), 32'd0);

    // Single read returning a fixed word.
    fix_rd = 32'h12345678;
    send(1'b0, 16'h0020, 32'hA5A5A5A5);
    wait_idle();
    check("rd_rsp_count", 32'(rsp_count), 32'd1);
    check("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    ctl_fix = 1'b0;

    // Fill the FIFO with the controller stalled, fifth waits for the first pop.
    ctl_mode = 2;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) send(1'(i & 1), 16'(16'h0100 + i), $urandom);
    check("full_req_ready", 32'(req_ready), 32'd0);
    present(1'b1, 16'h0104, $urandom);
    repeat (3) begin
      @(negedge clk);
      check("full_hold_ready", 32'(req_ready), 32'd0);
    end
    check("stall_no_issue", 32'(Valid), 32'd0);
    ctl_mode = 0;
    accept();
    wait_idle();

    // Stuck-high ready: timeout, err sticky, next request still serviced.
    rc = rsp_count;
    to_left = 1;
    send(1'b1, 16'h0200, 32'h0BADF00D);
    send(1'b0, 16'h0204, 32'h0);
    wait_idle();
    check("to_err", 32'(err), 32'd1);
    check("to_next_rsp", 32'(rsp_count - rc), 32'd1);

    // Random traffic with occasional timeouts.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) to_left = 1;
      send(1'($urandom_range(0, 1)), 16'($urandom), $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    to_left = 0;

    // Reset while a request waits in WAIT with three more queued.
    ctl_mode = 3;
    for (int i = 0; i < 4; i++) send(1'b0, 16'(16'h0300 + i), 32'h0);
    repeat (2) @(negedge clk);
    check("pre_rst_valid", 32'(Valid), 32'd1);
    rc = rsp_count;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(Valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    q_issue.delete();
    q_dur.delete();
    q_rsp.delete();
    @(negedge clk);
    ctl_mode = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_no_rsp", 32'(rsp_count - rc), 32'd0);

    check("left_issue", 32'(q_issue.size()), 32'd0);
    check("left_dur", 32'(q_dur.size()), 32'd0);
    check("left_rsp", 32'(q_rsp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
